plab4_net_router_output_ctrl_wh: RTL and testbench

//  Output-port controller for a mesh router: N-way round-robin arbitration

---
 rtl/plab4_net_router_output_ctrl_wh_pkg.sv | 12 +
 rtl/plab4_net_credit_counter.sv | 50 +++++
 rtl/plab4_net_router_output_ctrl_wh.sv | 125 ++++++++++++
 tb/tb_plab4_net_router_output_ctrl_wh.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/plab4_net_router_output_ctrl_wh_pkg.sv
// Shared definitions for the wormhole output-port controller: lock FSM
// state encoding and the default downstream buffer depth.
package plab4_net_router_output_ctrl_wh_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int DEFAULT_NUM_CREDITS = 4;

endpackage

// File: rtl/plab4_net_credit_counter.sv
// Downstream credit counter: starts full, -1 per sent flit, +1 per returned
// credit, and saturates at both ends.
module plab4_net_credit_counter
  import plab4_net_router_output_ctrl_wh_pkg::*;
#(
  parameter int NUM_CREDITS = DEFAULT_NUM_CREDITS,
  localparam int CRD_W = $clog2(NUM_CREDITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [CRD_W-1:0] count_o,
  output logic             zero_o
);

  localparam logic [CRD_W-1:0] FULL = CRD_W'(NUM_CREDITS);

  logic [CRD_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q != FULL)) begin
      count_d = count_q + CRD_W'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CRD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= FULL;
    end else begin
      count_q <= count_d;
    end
  end

  // A returned credit with the buffer already fully credited means the
  // downstream router freed a slot it never received.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(inc_i && !dec_i && (count_q == FULL)))
        else $error("credit_in received with credit count already full");
    end
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/plab4_net_router_output_ctrl_wh.sv
// Router output-port controller: round-robin arbitration, wormhole locking,
// credit flow control. Define PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN for counters.
module plab4_net_router_output_ctrl_wh
  import plab4_net_router_output_ctrl_wh_pkg::*;
#(
  parameter int NUM_INPUTS  = 3,
  parameter int NUM_CREDITS = DEFAULT_NUM_CREDITS,
  localparam int SEL_W = $clog2(NUM_INPUTS),
  localparam int CRD_W = $clog2(NUM_CREDITS + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_INPUTS-1:0] reqs,
  input  logic [NUM_INPUTS-1:0] tails,
  output logic [NUM_INPUTS-1:0] grants,
  output logic                  out_val,
  output logic [SEL_W-1:0]      xbar_sel,
  input  logic                  credit_in,
  output logic [CRD_W-1:0]      credits
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  ,
  output logic [31:0]           stat_flits,
  output logic [31:0]           stat_stalls
`endif
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] lock_q, lock_d;
  logic             arb_found;
  logic [SEL_W-1:0] arb_idx;
  logic             crd_zero;

  plab4_net_credit_counter #(.NUM_CREDITS(NUM_CREDITS)) u_credits (
    .clk     (clk),
    .reset   (reset),
    .inc_i   (credit_in),
    .dec_i   (out_val),
    .count_o (credits),
    .zero_o  (crd_zero)
  );

  // Round-robin search: first requester at or above the pointer, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      logic [SEL_W-1:0] cand;
      cand = SEL_W'((int'(ptr_q) + k) % NUM_INPUTS);
      if (!arb_found && reqs[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    lock_d   = lock_q;
    grants   = '0;
    xbar_sel = '0;
    if (!crd_zero) begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_found) begin
            grants[arb_idx] = 1'b1;
            xbar_sel        = arb_idx;
            ptr_d = (arb_idx == SEL_W'(NUM_INPUTS - 1)) ? '0 : arb_idx + SEL_W'(1);
            if (!tails[arb_idx]) begin
              state_d = ST_LOCKED;
              lock_d  = arb_idx;
            end
          end
        end
        ST_LOCKED: begin
          if (reqs[lock_q]) begin
            grants[lock_q] = 1'b1;
            xbar_sel       = lock_q;
            if (tails[lock_q]) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign out_val = |grants;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      lock_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
    end
  end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  logic [31:0] stat_flits_q, stat_stalls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_flits_q  <= '0;
      stat_stalls_q <= '0;
    end else begin
      if (out_val) begin
        stat_flits_q <= stat_flits_q + 32'd1;
      end
      if ((|reqs) && crd_zero) begin
        stat_stalls_q <= stat_stalls_q + 32'd1;
      end
    end
  end

  assign stat_flits  = stat_flits_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_plab4_net_router_output_ctrl_wh.sv
// Directed and randomized bench for the wormhole output-port controller,
// checked against a behavioural model of arbitration, locking and credits.
module tb_plab4_net_router_output_ctrl_wh;

  localparam int N = 3;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] reqs = '0;
  logic [2:0] tails = '0;
  logic       credit_in = 1'b0;
  logic [2:0] grants;
  logic       out_val;
  logic [1:0] xbar_sel;
  logic [2:0] credits;
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  logic [31:0] stat_flits;
  logic [31:0] stat_stalls;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: credits, RR pointer, wormhole lock.
  int m_cr;
  int m_ptr;
  int m_lock;
  bit m_locked;

  plab4_net_router_output_ctrl_wh #(.NUM_INPUTS(N), .NUM_CREDITS(C)) dut (
    .clk       (clk),
    .reset     (reset),
    .reqs      (reqs),
    .tails     (tails),
    .grants    (grants),
    .out_val   (out_val),
    .xbar_sel  (xbar_sel),
    .credit_in (credit_in),
    .credits   (credits)
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    ,
    .stat_flits  (stat_flits),
    .stat_stalls (stat_stalls)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  function automatic int model_winner(input logic [2:0] rq);
    if (m_cr == 0) return -1;
    if (m_locked) return rq[m_lock] ? m_lock : -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_ptr + k) % N;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_cr     = C;
    m_ptr    = 0;
    m_lock   = 0;
    m_locked = 1'b0;
  endtask

  // One cycle: drive at negedge, check combinational outputs and the
  // credit count before the edge, then advance the model past the edge.
  task automatic step(input logic [2:0] rq, input logic [2:0] tl, input logic ci,
                      output logic [2:0] g_obs, output logic [2:0] cr_obs);
    int w;
    @(negedge clk);
    reqs      = rq;
    tails     = tl;
    credit_in = ci;
    #1;
    w = model_winner(rq);
    chk("grants",   {29'd0, grants},   (w >= 0) ? (32'd1 << w) : 32'd0);
    chk("out_val",  {31'd0, out_val},  (w >= 0) ? 32'd1 : 32'd0);
    chk("xbar_sel", {30'd0, xbar_sel}, (w >= 0) ? w : 0);
    chk("credits",  {29'd0, credits},  m_cr);
    g_obs  = grants;
    cr_obs = credits;
    @(posedge clk);
    if (w >= 0) begin
      if (!m_locked) begin
        m_ptr = (w + 1) % N;
        if (!tl[w]) begin
          m_locked = 1'b1;
          m_lock   = w;
        end
      end else if (tl[w]) begin
        m_locked = 1'b0;
      end
    end
    m_cr = m_cr + (ci ? 1 : 0) - ((w >= 0) ? 1 : 0);
    if (m_cr > C) m_cr = C;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reqs      = '0;
    tails     = '0;
    credit_in = 1'b0;
    reset     = 1'b1;
    #1;
    model_reset();
    chk("rst_credits",  {29'd0, credits},  C);
    chk("rst_grants",   {29'd0, grants},   0);
    chk("rst_out_val",  {31'd0, out_val},  0);
    chk("rst_xbar_sel", {30'd0, xbar_sel}, 0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [2:0] g;
    logic [2:0] cr;

    // Reset values
    do_reset();

    // Round-robin rotation with single-flit packets, credits looped back
    step(3'b111, 3'b111, 1'b1, g, cr); chk("t2_g0", {29'd0, g}, 3'b001);
    step(3'b111, 3'b111, 1'b1, g, cr); chk("t2_g1", {29'd0, g}, 3'b010);
    step(3'b111, 3'b111, 1'b1, g, cr); chk("t2_g2", {29'd0, g}, 3'b100);
    step(3'b111, 3'b111, 1'b1, g, cr); chk("t2_g3", {29'd0, g}, 3'b001);
    chk("t2_cr", {29'd0, cr}, 4);

    // Input 1 holds the port for a 3-flit packet, then pointer moves to 2
    step(3'b111, 3'b000, 1'b1, g, cr); chk("t3_g0", {29'd0, g}, 3'b010);
    step(3'b111, 3'b000, 1'b1, g, cr); chk("t3_g1", {29'd0, g}, 3'b010);
    step(3'b111, 3'b010, 1'b1, g, cr); chk("t3_g2", {29'd0, g}, 3'b010);
    step(3'b111, 3'b111, 1'b1, g, cr); chk("t3_g3", {29'd0, g}, 3'b100);

    // Credit exhaustion and recovery
    for (int i = 0; i < 4; i++) begin
      step(3'b001, 3'b001, 1'b0, g, cr); chk("t4_stream", {29'd0, g}, 3'b001);
    end
    step(3'b001, 3'b001, 1'b0, g, cr); chk("t4_stall_g", {29'd0, g}, 3'b000);
    chk("t4_stall_cr", {29'd0, cr}, 0);
    step(3'b001, 3'b001, 1'b1, g, cr); chk("t4_ret_g", {29'd0, g}, 3'b000);
    step(3'b001, 3'b001, 1'b0, g, cr); chk("t4_resume_g", {29'd0, g}, 3'b001);
    chk("t4_resume_cr", {29'd0, cr}, 1);

    // Simultaneous grant and credit return at credits=2
    step(3'b000, 3'b000, 1'b1, g, cr);
    step(3'b000, 3'b000, 1'b1, g, cr);
    step(3'b001, 3'b001, 1'b1, g, cr); chk("t5_g", {29'd0, g}, 3'b001);
    chk("t5_cr_pre", {29'd0, cr}, 2);
    step(3'b000, 3'b000, 1'b0, g, cr); chk("t5_cr_post", {29'd0, cr}, 2);

    // Lock on input 2, bubbles, resume, then reset mid-packet
    step(3'b100, 3'b000, 1'b1, g, cr); chk("t6_head", {29'd0, g}, 3'b100);
    step(3'b001, 3'b001, 1'b0, g, cr); chk("t6_bub0", {29'd0, g}, 3'b000);
    step(3'b001, 3'b001, 1'b0, g, cr); chk("t6_bub1", {29'd0, g}, 3'b000);
    step(3'b101, 3'b000, 1'b0, g, cr); chk("t6_resume", {29'd0, g}, 3'b100);
    do_reset();
    step(3'b011, 3'b011, 1'b0, g, cr); chk("t6_post_rst", {29'd0, g}, 3'b001);

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      logic [2:0] rq;
      logic [2:0] tl;
      logic       ci;
      rq = 3'($urandom_range(0, 7));
      tl = 3'($urandom_range(0, 7));
      ci = ($urandom_range(0, 2) != 0) && (m_cr < C);
      step(rq, tl, ci, g, cr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
